// File: rtl/led_bank_arbiter.sv
// Round-robin owner of the 16-LED bank with a minimum hold per grant and an idle heartbeat on LED[0].
// grant/busy update on the edge that samples req; LED follows one cycle after the grant it shows.
module led_bank_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int HOLD_CYCLES   = 100000,
  parameter int HEARTBEAT_DIV = 50000000
) (
  input  logic                   CLK,
  input  logic                   CPU_RESETN,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  req_pattern,
  output logic [NUM_REQ-1:0]     grant,
  output logic [15:0]            LED,
  output logic                   busy
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int HB_W   = (HEARTBEAT_DIV > 1) ? $clog2(HEARTBEAT_DIV) : 1;
  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HB_W-1:0]   HB_MAX   = HB_W'(HEARTBEAT_DIV - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              r_state;
  logic [NUM_REQ-1:0]  r_grant;
  logic [15:0]         r_led;
  logic                r_busy;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [HB_W-1:0]     r_hb_cnt;
  logic                r_hb;
  logic [PTR_W-1:0]    r_ptr;
  logic [PTR_W-1:0]    r_gidx;

  logic                w_hb_wrap;
  logic                w_hb_nxt;
  logic                w_hold_done;
  logic [NUM_REQ-1:0]  w_cand;
  logic [PTR_W-1:0]    w_start;
  logic                w_found;
  logic [PTR_W-1:0]    w_win;
  int                  w_idx;

  function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] i);
    if (int'(i) == NUM_REQ - 1) return '0;
    else return i + PTR_W'(1);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] i);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << i;
  endfunction

  assign w_hb_wrap   = (r_hb_cnt == HB_MAX);
  assign w_hb_nxt    = r_hb ^ w_hb_wrap;
  assign w_hold_done = (r_hold_cnt == HOLD_MAX);

  // While granted, the current owner is masked and the search begins just past it,
  // so any other requester wins before the owner can be re-selected.
  always_comb begin
    w_cand  = req;
    w_start = r_ptr;
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    if (r_state == GRANT) begin
      w_cand[r_gidx] = 1'b0;
      w_start        = next_idx(r_gidx);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = (int'(w_start) + i) % NUM_REQ;
      if (!w_found && w_cand[w_idx]) begin
        w_found = 1'b1;
        w_win   = PTR_W'(w_idx);
      end
    end
  end

  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_led      <= '0;
      r_busy     <= 1'b0;
      r_hold_cnt <= '0;
      r_hb_cnt   <= '0;
      r_hb       <= 1'b0;
      r_ptr      <= '0;
      r_gidx     <= '0;
    end else begin
      r_hb_cnt <= w_hb_wrap ? '0 : r_hb_cnt + 1'b1;
      r_hb     <= w_hb_nxt;
      r_led    <= (r_state == GRANT) ? req_pattern[16*r_gidx +: 16] : {15'b0, w_hb_nxt};
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state    <= GRANT;
            r_grant    <= onehot(w_win);
            r_gidx     <= w_win;
            r_ptr      <= next_idx(w_win);
            r_hold_cnt <= '0;
            r_busy     <= 1'b1;
          end
        end
        GRANT: begin
          if (!w_hold_done) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end else if (w_found) begin
            r_grant    <= onehot(w_win);
            r_gidx     <= w_win;
            r_ptr      <= next_idx(w_win);
            r_hold_cnt <= '0;
          end else if (!req[r_gidx]) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_busy     <= 1'b0;
            r_ptr      <= next_idx(r_gidx);
            r_hold_cnt <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant = r_grant;
  assign LED   = r_led;
  assign busy  = r_busy;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed bench for led_bank_arbiter: NUM_REQ=4, HOLD_CYCLES=4, HEARTBEAT_DIV=8.
module tb_led_bank_arbiter;

  logic        CLK;
  logic        CPU_RESETN;
  logic [3:0]  req;
  logic [63:0] req_pattern;
  logic [3:0]  grant;
  logic [15:0] LED;
  logic        busy;

  int n_pass;
  int n_total;
  int edge_cnt;
  logic [15:0] pat [4];

  led_bank_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(4), .HEARTBEAT_DIV(8)) dut (
    .CLK(CLK), .CPU_RESETN(CPU_RESETN), .req(req), .req_pattern(req_pattern),
    .grant(grant), .LED(LED), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Edges since the last reset release; the heartbeat LED follows floor(edges/8) mod 2.
  always @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) edge_cnt <= 0;
    else edge_cnt <= edge_cnt + 1;
  end

  function automatic logic [15:0] hb_led();
    logic b;
    b = ((edge_cnt / 8) % 2) == 1;
    return {15'b0, b};
  endfunction

  task automatic apply_reset();
    CPU_RESETN = 1'b0;
    repeat (3) @(negedge CLK);
    CPU_RESETN = 1'b1;
  endtask

  task automatic test_reset();
    CPU_RESETN = 1'b0;
    req = 4'b0000;
    repeat (10) @(negedge CLK);
    n_total++;
    if ({grant, LED, busy} !== 21'b0) $display("FAIL reset: grant=%b LED=%h busy=%b want all 0", grant, LED, busy);
    else n_pass++;
    CPU_RESETN = 1'b1;
  endtask

  task automatic test_heartbeat();
    for (int k = 1; k <= 20; k++) begin
      logic [15:0] exp_led;
      @(negedge CLK);
      exp_led = {15'b0, ((k / 8) % 2) == 1};
      n_total++;
      if (LED !== exp_led || grant !== 4'b0 || busy !== 1'b0)
        $display("FAIL heartbeat k=%0d: LED=%h grant=%b busy=%b want LED=%h grant=0 busy=0", k, LED, grant, busy, exp_led);
      else n_pass++;
    end
  endtask

  task automatic test_single_pulse();
    req = 4'b0100;
    @(negedge CLK);
    n_total++;
    if (grant !== 4'b0100 || busy !== 1'b1 || LED !== hb_led())
      $display("FAIL pulse_grant: grant=%b busy=%b LED=%h want 0100 1 %h", grant, busy, LED, hb_led());
    else n_pass++;
    req = 4'b0000;
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK);
      n_total++;
      if (grant !== 4'b0100 || LED !== 16'hA5A5)
        $display("FAIL pulse_hold k=%0d: grant=%b LED=%h want 0100 a5a5", k, grant, LED);
      else n_pass++;
    end
    @(negedge CLK);
    n_total++;
    if (grant !== 4'b0 || busy !== 1'b0 || LED !== 16'hA5A5)
      $display("FAIL pulse_release: grant=%b busy=%b LED=%h want 0000 0 a5a5", grant, busy, LED);
    else n_pass++;
    @(negedge CLK);
    n_total++;
    if (LED !== hb_led() || grant !== 4'b0)
      $display("FAIL pulse_hb_return: LED=%h grant=%b want %h 0000", LED, grant, hb_led());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    req = 4'b1111;
    apply_reset();
    for (int k = 1; k <= 20; k++) begin
      logic [3:0] exp_g;
      @(negedge CLK);
      exp_g = 4'b0001 << (((k - 1) / 4) % 4);
      n_total++;
      if (grant !== exp_g || busy !== 1'b1)
        $display("FAIL rr_grant k=%0d: grant=%b busy=%b want %b 1", k, grant, busy, exp_g);
      else n_pass++;
      if (k >= 2) begin
        n_total++;
        if (LED !== pat[((k - 2) / 4) % 4])
          $display("FAIL rr_led k=%0d: LED=%h want %h", k, LED, pat[((k - 2) / 4) % 4]);
        else n_pass++;
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_ptr_after_release();
    req = 4'b0001;
    apply_reset();
    @(negedge CLK);
    n_total++;
    if (grant !== 4'b0001) $display("FAIL ptr_first: grant=%b want 0001", grant);
    else n_pass++;
    req = 4'b0000;
    repeat (4) @(negedge CLK);
    n_total++;
    if (grant !== 4'b0000 || busy !== 1'b0) $display("FAIL ptr_idle: grant=%b busy=%b want 0000 0", grant, busy);
    else n_pass++;
    req = 4'b0011;
    @(negedge CLK);
    n_total++;
    if (grant !== 4'b0010) $display("FAIL ptr_resume: grant=%b want 0010", grant);
    else n_pass++;
    req = 4'b0001;
    repeat (3) @(negedge CLK);
    n_total++;
    if (grant !== 4'b0010) $display("FAIL ptr_min_hold: grant=%b want 0010", grant);
    else n_pass++;
    @(negedge CLK);
    n_total++;
    if (grant !== 4'b0001 || busy !== 1'b1) $display("FAIL ptr_handover: grant=%b busy=%b want 0001 1", grant, busy);
    else n_pass++;
    req = 4'b0000;
  endtask

  task automatic test_long_hold();
    req = 4'b1000;
    apply_reset();
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      n_total++;
      if (grant !== 4'b1000) $display("FAIL long_hold k=%0d: grant=%b want 1000", k, grant);
      else n_pass++;
    end
    req = 4'b1010;
    @(negedge CLK);
    n_total++;
    if (grant !== 4'b0010) $display("FAIL long_preempt: grant=%b want 0010", grant);
    else n_pass++;
    req = 4'b0000;
  endtask

  task automatic test_async_reset();
    req = 4'b0100;
    apply_reset();
    repeat (2) @(negedge CLK);
    n_total++;
    if (grant !== 4'b0100 || LED !== 16'hA5A5 || busy !== 1'b1)
      $display("FAIL arst_pre: grant=%b LED=%h busy=%b want 0100 a5a5 1", grant, LED, busy);
    else n_pass++;
    #2;
    CPU_RESETN = 1'b0;
    #1;
    n_total++;
    if (grant !== 4'b0 || LED !== 16'h0 || busy !== 1'b0)
      $display("FAIL arst_immediate: grant=%b LED=%h busy=%b want 0", grant, LED, busy);
    else n_pass++;
    req = 4'b1111;
    repeat (2) @(negedge CLK);
    n_total++;
    if (grant !== 4'b0 || busy !== 1'b0)
      $display("FAIL arst_held: grant=%b busy=%b want 0000 0", grant, busy);
    else n_pass++;
    CPU_RESETN = 1'b1;
    @(negedge CLK);
    n_total++;
    if (grant !== 4'b0001) $display("FAIL arst_ptr0: grant=%b want 0001", grant);
    else n_pass++;
    req = 4'b0000;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    pat[0] = 16'h1111;
    pat[1] = 16'h2222;
    pat[2] = 16'hA5A5;
    pat[3] = 16'h3333;
    req_pattern = {pat[3], pat[2], pat[1], pat[0]};
    req = 4'b0000;
    CPU_RESETN = 1'b0;
    test_reset();
    test_heartbeat();
    test_single_pulse();
    test_back_to_back();
    test_ptr_after_release();
    test_long_hold();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
